// File: rtl/result_display_ctrl.sv
// Latches the ALU result on done, converts it to BCD by shift-add-3 and
// scans it onto a 4-digit active-low 7-segment display with sign and blanking.
module result_display_ctrl #(
    parameter int DATA_W      = 8,
    parameter int SIGNED      = 1,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              CLK,
    input  logic              clear_n,
    input  logic              done,
    input  logic [DATA_W-1:0] result,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              valid,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CONVERT,
        S_SHOW
    } state_e;

    state_e            state_q, state_d;
    logic              done_q;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic              sign_q, sign_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     div_q, div_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic [11:0]       adj;
    logic [6:0]        dig_seg;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'd0:    hex7 = 7'b1000000;
            4'd1:    hex7 = 7'b1111001;
            4'd2:    hex7 = 7'b0100100;
            4'd3:    hex7 = 7'b0110000;
            4'd4:    hex7 = 7'b0011001;
            4'd5:    hex7 = 7'b0010010;
            4'd6:    hex7 = 7'b0000010;
            4'd7:    hex7 = 7'b1111000;
            4'd8:    hex7 = 7'b0000000;
            4'd9:    hex7 = 7'b0010000;
            default: hex7 = '1;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        an_d    = 4'b1111;
        seg_d   = '1;
        valid_d = 1'b0;
        busy_d  = 1'b0;

        adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (idx_q)
            2'd0:    dig_seg = hex7(bcd_q[3:0]);
            2'd1:    dig_seg = (bcd_q[11:4] == '0) ? '1 : hex7(bcd_q[7:4]);
            2'd2:    dig_seg = (bcd_q[11:8] == '0) ? '1 : hex7(bcd_q[11:8]);
            default: dig_seg = sign_q ? 7'b0111111 : '1;
        endcase

        // Outputs are decoded from the current state and registered, so they
        // trail the state register by one edge.
        case (state_q)
            S_IDLE: begin
                if (done && !done_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                busy_d = 1'b1;
                if (!done) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = result;
                    sign_d  = (SIGNED != 0) && result[DATA_W-1];
                    mag_d   = sign_d ? (~result + DATA_W'(1)) : result;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                busy_d = 1'b1;
                if (!done) begin
                    state_d = S_IDLE;
                end else begin
                    bcd_d = {adj[10:0], mag_q[DATA_W-1]};
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        state_d = S_SHOW;
                        div_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                valid_d = 1'b1;
                an_d    = ~(4'b0001 << idx_q);
                seg_d   = dig_seg;
                if (!done) begin
                    state_d = S_IDLE;
                end else if (result != res_q) begin
                    state_d = S_LOAD;
                end else if (div_q == DW'(REFRESH_DIV - 1)) begin
                    div_d = '0;
                    idx_d = idx_q + 2'd1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            res_q   <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done;
            res_q   <= res_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Directed bench for result_display_ctrl: a signed 8-bit and an unsigned
// 9-bit instance, both scanning 4 cycles per digit.
module tb_result_display_ctrl;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;

    logic       CLK = 1'b0;
    logic       clear_n = 1'b1;
    logic       doneA = 1'b0, doneB = 1'b0;
    logic [7:0] resultA = '0;
    logic [8:0] resultB = '0;
    logic [3:0] anA, anB;
    logic [6:0] segA, segB;
    logic       validA, validB, busyA, busyB;

    int unsigned total = 0;
    int unsigned passed = 0;

    result_display_ctrl #(.DATA_W(8), .SIGNED(1), .REFRESH_DIV(4)) dutA (
        .CLK(CLK), .clear_n(clear_n), .done(doneA), .result(resultA),
        .an(anA), .seg(segA), .valid(validA), .busy(busyA)
    );

    result_display_ctrl #(.DATA_W(9), .SIGNED(0), .REFRESH_DIV(4)) dutB (
        .CLK(CLK), .clear_n(clear_n), .done(doneB), .result(resultB),
        .an(anB), .seg(segB), .valid(validB), .busy(busyB)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Expects the first digit-0 cycle to be the current sample.
    task automatic scan_chk(input bit sel, input string tag,
                            input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] es;
        logic [3:0] ea;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick(1);
            case (k / 4)
                0:       begin es = e0; ea = 4'b1110; end
                1:       begin es = e1; ea = 4'b1101; end
                2:       begin es = e2; ea = 4'b1011; end
                default: begin es = e3; ea = 4'b0111; end
            endcase
            chk($sformatf("%s_an%0d", tag, k), {12'd0, sel ? anB : anA}, {12'd0, ea});
            chk($sformatf("%s_seg%0d", tag, k), {9'd0, sel ? segB : segA}, {9'd0, es});
        end
    endtask

    // Idles instance A, then converts res and checks latency up to valid.
    task automatic conv_a(input logic [7:0] res, input string tag);
        doneA = 1'b0;
        tick(2);
        resultA = res;
        doneA = 1'b1;
        tick(2);
        chk({tag, "_busy"}, {15'd0, busyA}, 16'd1);
        tick(8);
        chk({tag, "_valid_early"}, {15'd0, validA}, 16'd0);
        tick(1);
        chk({tag, "_valid_on"}, {15'd0, validA}, 16'd1);
        chk({tag, "_busy_off"}, {15'd0, busyA}, 16'd0);
    endtask

    initial begin
        logic bad;

        #1 clear_n = 1'b0;
        #2;
        chk("rst_an", {12'd0, anA}, 16'hF);
        chk("rst_seg", {9'd0, segA}, 16'h7F);
        chk("rst_valid", {15'd0, validA}, 16'd0);
        chk("rst_busy", {15'd0, busyA}, 16'd0);
        tick(2);
        clear_n = 1'b1;
        tick(3);
        chk("idle_an", {12'd0, anA}, 16'hF);
        chk("idle_valid", {15'd0, validA}, 16'd0);

        conv_a(8'h7B, "c123");
        scan_chk(1'b0, "s123", BL, S1, S2, S3);

        conv_a(8'hF6, "cm10");
        scan_chk(1'b0, "sm10", MI, BL, S1, S0);

        conv_a(8'h80, "cm128");
        scan_chk(1'b0, "sm128", MI, S1, S2, S8);

        conv_a(8'h00, "c0");
        scan_chk(1'b0, "s0", BL, BL, BL, S0);

        // Result change with done held triggers a reconversion
        conv_a(8'h05, "c5");
        scan_chk(1'b0, "s5", BL, BL, BL, S5);
        resultA = 8'h07;
        tick(1);
        chk("chg_valid_hold", {15'd0, validA}, 16'd1);
        tick(1);
        chk("chg_valid_drop", {15'd0, validA}, 16'd0);
        tick(8);
        chk("chg_valid_low", {15'd0, validA}, 16'd0);
        tick(1);
        chk("chg_valid_back", {15'd0, validA}, 16'd1);
        scan_chk(1'b0, "s7", BL, BL, BL, S7);

        // Abort in the third CONVERT cycle
        doneA = 1'b0;
        tick(2);
        resultA = 8'h2A;
        doneA = 1'b1;
        tick(4);
        chk("abort_busy", {15'd0, busyA}, 16'd1);
        doneA = 1'b0;
        tick(2);
        chk("abort_busy_off", {15'd0, busyA}, 16'd0);
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (validA !== 1'b0 || anA !== 4'b1111 || segA !== BL) bad = 1'b1;
            tick(1);
        end
        chk("abort_blank", {15'd0, bad}, 16'd0);

        // Asynchronous reset in the middle of SHOW
        conv_a(8'h7B, "crst");
        tick(3);
        chk("pre_rst_valid", {15'd0, validA}, 16'd1);
        #3 clear_n = 1'b0;
        doneA = 1'b0;
        #1;
        chk("mid_rst_an", {12'd0, anA}, 16'hF);
        chk("mid_rst_seg", {9'd0, segA}, 16'h7F);
        chk("mid_rst_valid", {15'd0, validA}, 16'd0);
        tick(1);
        clear_n = 1'b1;
        tick(4);
        chk("post_rst_an", {12'd0, anA}, 16'hF);
        chk("post_rst_valid", {15'd0, validA}, 16'd0);

        // Unsigned 9-bit instance
        resultB = 9'h1FF;
        doneB = 1'b1;
        tick(11);
        chk("b_valid_early", {15'd0, validB}, 16'd0);
        tick(1);
        chk("b_valid_on", {15'd0, validB}, 16'd1);
        scan_chk(1'b1, "s511", BL, S5, S1, S1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
- Consumer end of the calculator control path.
- The control FSM raises Done_out once both operands are in the register file and the ALU mode is applied. This block watches that done level, latches the ALU result, and converts it to BCD sequentially (shift-add-3).
- It then drives a 4-digit, time-multiplexed, active-low 7-segment display with sign and leading-zero blanking.
- It re-converts automatically whenever the result changes while done stays high, e.g. when the mode switches change in the calculation state.

Parameters:
- DATA_W, 8, width of ALU result. Legal range 4..9 when SIGNED=0, 4..10 when SIGNED=1, so the magnitude fits 3 decimal digits.
- SIGNED, 1, 1 = result is two's complement; 0 = result is unsigned.
- REFRESH_DIV, 50000, CLK cycles per displayed digit. Minimum 2.

Ports:
- CLK, input, 1, system clock; all state changes on rising edge.
- clear_n, input, 1, asynchronous active-low reset.
- done, input, 1, result-ready level from the control FSM (its Done_out).
- result, input, DATA_W, ALU output.
- an, output, 4, digit anodes, active low, one-hot-low while displaying.
- seg, output, 7, segments {g,f,e,d,c,b,a}, active low.
- valid, output, 1, high while digits hold a completed conversion.
- busy, output, 1, high in LOAD/CONVERT.

Behaviour:
- Reset (clear_n low, asynchronous): state=IDLE, an=4'b1111, seg=7'b1111111, valid=0, busy=0. All counters and latches are zero, and done_q=0.
- done_q is done registered once. A rising edge is detected when done=1 and done_q=0.
- State IDLE: display blank.
  - done rising edge → LOAD.
- State LOAD (1 cycle), busy=1:
  - latch result into res_q;
  - sign = SIGNED & res_q[MSB];
  - mag = sign ? -res_q : res_q, computed as unsigned DATA_W bits, so -2^(DATA_W-1) yields 2^(DATA_W-1);
  - clear BCD, bit count=0;
  - → CONVERT.
- State CONVERT (exactly DATA_W cycles), busy=1:
  - each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,mag} left by 1;
  - after the DATA_W-th shift → SHOW;
  - result changes during CONVERT are ignored.
- State SHOW: valid=1, busy=0.
  - Digits are latched; the scan runs.
  - If done=0 → IDLE (blank) next cycle.
  - Else if result≠res_q → LOAD, with valid dropping the cycle after the mismatch is sampled.
  - The done=0 check has priority over the mismatch check.
- done falling in LOAD or CONVERT → IDLE next edge; the conversion is discarded and valid stays 0.
- Latency: first CLK edge sampling done=1 → LOAD; valid=1 exactly DATA_W+2 edges after that edge.
- Scan (SHOW only):
  - divider counts 0..REFRESH_DIV-1;
  - at wrap the digit index advances 0→1→2→3→0;
  - index resets to 0 and divider to 0 on SHOW entry;
  - digit i drives an[i]=0, others 1.
- Digit content:
  - d0 = ones, always shown;
  - d1 = tens, blank if hundreds=0 and tens=0;
  - d2 = hundreds, blank if 0;
  - d3 = '-' (7'b0111111) if sign, else blank.
  - Blank is seg=7'b1111111, with the anode still driven.
  - Hex decode for 0-9 uses standard active-low patterns, e.g. 0=1000000, 1=1111001, 7=1111000, 8=0000000.
- Outside SHOW: an=1111, seg=1111111.
- done high at reset release counts as a rising edge on the first sampled edge.

Test Plan:
- Reset: assert clear_n=0 mid-SHOW → same-time an=1111, seg=1111111, valid=0; release → stays IDLE while done=0.
- DATA_W=8, SIGNED=1, REFRESH_DIV=4; result=8'h7B, done 0→1 → valid=1 exactly 10 edges later.
  - Scan d0=3 (0110000), d1=2 (0100100), d2=1 (1111001), d3 blank.
  - Each digit is held 4 cycles, in order an=1110,1101,1011,0111.
- result=8'hF6 (-10) → d3='-', d2 blank, d1=1, d0=0.
- result=8'h80 → '-',1,2,8; result=8'h00 → blank,blank,blank,0.
- SHOW with result=5, change result to 7 with done held → valid low for DATA_W+1 cycles, then d0=7; d1..d3 blank.
- done falls in CONVERT cycle 3 → IDLE next edge, valid never asserts, display blank.
- SIGNED=0, DATA_W=9, result=9'h1FF → blank,5,1,1.
